// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and count-decoded flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  w_en,
   output logic                  full,
   output logic                  almost_full,
   output logic [DATA_WIDTH-1:0] r_data,
   input  logic                  r_en,
   output logic                  empty,
   output logic                  almost_empty
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  w_ok;
   logic                  r_ok;

   // Flags depend only on the registered count, so they settle with it.
   assign full         = (count == FULL_CNT);
   assign almost_full  = (count >= AF_CNT);
   assign empty        = (count == '0);
   assign almost_empty = (count <= AE_CNT);

   assign w_ok = w_en & ~full;
   assign r_ok = r_en & ~empty;

   // Storage array: written on accepted writes, deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_ok) mem[wr_ptr] <= w_data;
   end

   // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (w_ok) wr_ptr <= wr_ptr + AW'(1);
         if (r_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({w_ok, r_ok})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

   // Read data register: loads on an accepted read, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (r_ok) begin
         r_data <= mem[rd_ptr];
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   // Sticky error flags for rejected requests, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en && full)  overflow  <= 1'b1;
         if (r_en && empty) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: a default instance and one with AF=12/AE=3
// share the same stimulus and are checked against a reference model.
module tb_fifo;

   logic        clk;
   logic        rst_n;
   logic [31:0] w_data;
   logic        w_en;
   logic        r_en;

   logic        full0, af0, empty0, ae0;
   logic [31:0] rd0;
   logic        full1, af1, empty1, ae1;
   logic [31:0] rd1;
`ifdef FIFO_ERR_FLAGS_EN
   logic        ovf0, unf0, ovf1, unf1;
`endif

   fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_data       (w_data),
      .w_en         (w_en),
      .full         (full0),
      .almost_full  (af0),
      .r_data       (rd0),
      .r_en         (r_en),
      .empty        (empty0),
      .almost_empty (ae0)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow     (ovf0),
      .underflow    (unf0)
`endif
   );

   fifo #(.AF_LEVEL(12), .AE_LEVEL(3)) dut_t (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_data       (w_data),
      .w_en         (w_en),
      .full         (full1),
      .almost_full  (af1),
      .r_data       (rd1),
      .r_en         (r_en),
      .empty        (empty1),
      .almost_empty (ae1)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow     (ovf1),
      .underflow    (unf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] sb [$];
   int          cnt;
   logic [31:0] exp_rd;
   logic        ovf_m;
   logic        unf_m;
   int          n_chk;
   int          n_pass;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic check_all();
      check("rdata",    rd0,    exp_rd);
      check("empty",    empty0, 32'(cnt == 0));
      check("a_empty",  ae0,    32'(cnt <= 1));
      check("a_full",   af0,    32'(cnt >= 15));
      check("full",     full0,  32'(cnt == 16));
      check("t_rdata",  rd1,    exp_rd);
      check("t_empty",  empty1, 32'(cnt == 0));
      check("t_a_empty", ae1,   32'(cnt <= 3));
      check("t_a_full", af1,    32'(cnt >= 12));
      check("t_full",   full1,  32'(cnt == 16));
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow",   ovf0, 32'(ovf_m));
      check("underflow",  unf0, 32'(unf_m));
      check("t_overflow", ovf1, 32'(ovf_m));
      check("t_underflow", unf1, 32'(unf_m));
`endif
   endtask

   task automatic step(input bit w, input bit r, input logic [31:0] d);
      bit wa;
      bit ra;
      @(negedge clk);
      w_en   = w;
      r_en   = r;
      w_data = d;
      wa = w && (cnt < 16);
      ra = r && (cnt > 0);
      if (ra) begin
         exp_rd = sb.pop_front();
         cnt--;
      end
      if (wa) begin
         sb.push_back(d);
         cnt++;
      end
      if (w && !wa) ovf_m = 1'b1;
      if (r && !ra) unf_m = 1'b1;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic model_reset();
      sb.delete();
      cnt    = 0;
      exp_rd = '0;
      ovf_m  = 1'b0;
      unf_m  = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      w_en   = 1'b0;
      r_en   = 1'b0;
      w_data = '0;
      rst_n  = 1'b1;
      model_reset();

      #1 rst_n = 1'b0;
      #1 check_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // fill 1..16, then a dropped 17th write
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 32'(i));
      step(1'b1, 1'b0, 32'hDEAD);

      // drain in order, then one read from empty
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      check("hold_last", rd0, 32'h10);

      // simultaneous read/write at 8 entries
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h200 + 32'(i));
      check("cnt_hold8", 32'(cnt), 32'd8);

      // fill up, then simultaneous while full
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h300 + 32'(i));
      step(1'b1, 1'b1, 32'hBEEF);
      check("full_rw_cnt", 32'(cnt), 32'd15);

      // drain, then simultaneous while empty
      while (cnt > 0) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 32'h400);

      // random traffic
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

      // reset mid-stream with 5 entries stored
      while (cnt > 0) step(1'b0, 1'b1, '0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h500 + 32'(i));
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      w_en  = 1'b0;
      r_en  = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 32'hABC);
      step(1'b0, 1'b1, '0);
      check("post_reset", rd0, 32'hABC);
      step(1'b0, 1'b1, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
